mmc1: RTL and testbench

MMC1 -- requirements
Module: mmc1

---
 rtl/mmc1_pkg.sv | 27 ++
 rtl/mmc1_serial_port.sv | 51 +++++
 rtl/mmc1.sv | 105 ++++++++++
 tb/tb_mmc1.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mmc1_pkg.sv
// Shared encodings for the MMC1 mapper: register selects, mirroring and PRG banking modes.
package mmc1_pkg;

   typedef enum logic [1:0] {
      SEL_CTRL = 2'b00,
      SEL_CHR0 = 2'b01,
      SEL_CHR1 = 2'b10,
      SEL_PRG  = 2'b11
   } reg_sel_t;

   typedef enum logic [1:0] {
      MIR_ONE_LO = 2'b00,
      MIR_ONE_HI = 2'b01,
      MIR_VERT   = 2'b10,
      MIR_HORZ   = 2'b11
   } mirror_t;

   typedef enum logic [1:0] {
      PRG_32K_A  = 2'b00,
      PRG_32K_B  = 2'b01,
      PRG_FIX_LO = 2'b10,
      PRG_FIX_HI = 2'b11
   } prg_mode_t;

   localparam logic [4:0] CTRL_RESET = 5'b01100;

endpackage

// File: rtl/mmc1_serial_port.sv
// CPU-side serial loader: detects first-cycle ROM writes and assembles 5-bit register values.
module mmc1_serial_port
   import mmc1_pkg::*;
(
   input  logic       M2,
   input  logic       RST,
   input  logic       nROMSEL,
   input  logic       CPU_RnW,
   input  logic       CPU_D0,
   input  logic       CPU_D7,
   input  logic       CPU_A13,
   input  logic       CPU_A14,
   output logic [4:0] load_value,
   output logic       load_strobe,
   output reg_sel_t   load_sel,
   output logic       shift_clear
);

   logic       strobe;
   logic       prev_strobe;
   logic       accept;
   // Holds SR[4:1]; SR[0] is always shifted out before the register can be read.
   logic [3:0] sr;
   logic [2:0] count;

   assign strobe      = ~nROMSEL & ~CPU_RnW;
   assign accept      = strobe & ~prev_strobe;
   assign shift_clear = accept & CPU_D7;
   assign load_strobe = accept & ~CPU_D7 & (count == 3'd4);
   assign load_value  = {CPU_D0, sr};
   assign load_sel    = reg_sel_t'({CPU_A14, CPU_A13});

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge M2 or posedge RST) begin
      if (RST) begin
         sr          <= '0;
         count       <= '0;
         prev_strobe <= 1'b0;
      end else begin
         prev_strobe <= strobe;
         if (shift_clear || load_strobe) begin
            sr    <= '0;
            count <= '0;
         end else if (accept) begin
            sr    <= {CPU_D0, sr[3:1]};
            count <= count + 3'd1;
         end
      end
   end

endmodule

// File: rtl/mmc1.sv
// MMC1 mapper top: control/bank registers plus PRG, CHR, SRAM and nametable decode.
module mmc1
   import mmc1_pkg::*;
(
   input  logic M2,
   input  logic RST,
   input  logic nROMSEL,
   input  logic CPU_RnW,
   input  logic CPU_D0,
   input  logic CPU_D7,
   input  logic CPU_A13,
   input  logic CPU_A14,
   input  logic PPU_A10,
   input  logic PPU_A11,
   input  logic PPU_A12,
   output logic PRG_A14,
   output logic PRG_A15,
   output logic PRG_A16,
   output logic PRG_A17,
   output logic CHR_A12,
   output logic CHR_A13,
   output logic CHR_A14,
   output logic CHR_A15,
   output logic CHR_A16,
   output logic PRG_nCE,
   output logic SRAM_CE,
   output logic CIRAM_A10
);

   logic [4:0] ctrl;
   logic [4:0] chr0;
   logic [4:0] chr1;
   logic [4:0] prg;
   logic [4:0] load_value;
   logic       load_strobe;
   logic       shift_clear;
   reg_sel_t   load_sel;
   logic [3:0] prg_a;
   logic [4:0] chr_a;
   logic       ciram;

   mmc1_serial_port u_serial (
      .M2          (M2),
      .RST         (RST),
      .nROMSEL     (nROMSEL),
      .CPU_RnW     (CPU_RnW),
      .CPU_D0      (CPU_D0),
      .CPU_D7      (CPU_D7),
      .CPU_A13     (CPU_A13),
      .CPU_A14     (CPU_A14),
      .load_value  (load_value),
      .load_strobe (load_strobe),
      .load_sel    (load_sel),
      .shift_clear (shift_clear)
   );

   always_ff @(posedge M2 or posedge RST) begin
      if (RST) begin
         ctrl <= CTRL_RESET;
         chr0 <= '0;
         chr1 <= '0;
         prg  <= '0;
      end else if (shift_clear) begin
         ctrl[3:2] <= 2'b11;
      end else if (load_strobe) begin
         case (load_sel)
            SEL_CTRL: ctrl <= load_value;
            SEL_CHR0: chr0 <= load_value;
            SEL_CHR1: chr1 <= load_value;
            SEL_PRG:  prg  <= load_value;
            default:  ;
         endcase
      end
   end

   // NOTE: every decode output gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      ciram = 1'b0;
      case (mirror_t'(ctrl[1:0]))
         MIR_ONE_LO: ciram = 1'b0;
         MIR_ONE_HI: ciram = 1'b1;
         MIR_VERT:   ciram = PPU_A10;
         MIR_HORZ:   ciram = PPU_A11;
         default:    ciram = 1'b0;
      endcase

      prg_a = {prg[3:1], CPU_A14};
      case (prg_mode_t'(ctrl[3:2]))
         PRG_FIX_LO: prg_a = CPU_A14 ? prg[3:0] : 4'b0000;
         PRG_FIX_HI: prg_a = CPU_A14 ? 4'b1111  : prg[3:0];
         default:    prg_a = {prg[3:1], CPU_A14};
      endcase

      chr_a = {chr0[4:1], PPU_A12};
      if (ctrl[4])
         chr_a = PPU_A12 ? chr1 : chr0;
   end

   assign {PRG_A17, PRG_A16, PRG_A15, PRG_A14}          = prg_a;
   assign {CHR_A16, CHR_A15, CHR_A14, CHR_A13, CHR_A12} = chr_a;
   assign CIRAM_A10 = ciram;
   assign PRG_nCE   = nROMSEL;
   assign SRAM_CE   = nROMSEL & CPU_A14 & CPU_A13 & ~prg[4];

endmodule

// File: tb/tb_mmc1.sv
// Directed self-checking bench for the mmc1 mapper.
module tb_mmc1;

   logic M2 = 1'b0;
   logic RST = 1'b1;
   logic nROMSEL = 1'b1;
   logic CPU_RnW = 1'b1;
   logic CPU_D0 = 1'b0;
   logic CPU_D7 = 1'b0;
   logic CPU_A13 = 1'b0;
   logic CPU_A14 = 1'b0;
   logic PPU_A10 = 1'b0;
   logic PPU_A11 = 1'b0;
   logic PPU_A12 = 1'b0;
   logic PRG_A14, PRG_A15, PRG_A16, PRG_A17;
   logic CHR_A12, CHR_A13, CHR_A14, CHR_A15, CHR_A16;
   logic PRG_nCE, SRAM_CE, CIRAM_A10;

   int n_assert = 0;
   int n_fail   = 0;

   wire [4:0] prg_a = {1'b0, PRG_A17, PRG_A16, PRG_A15, PRG_A14};
   wire [4:0] chr_a = {CHR_A16, CHR_A15, CHR_A14, CHR_A13, CHR_A12};

   always #5 M2 = ~M2;

   mmc1 dut (
      .M2        (M2),
      .RST       (RST),
      .nROMSEL   (nROMSEL),
      .CPU_RnW   (CPU_RnW),
      .CPU_D0    (CPU_D0),
      .CPU_D7    (CPU_D7),
      .CPU_A13   (CPU_A13),
      .CPU_A14   (CPU_A14),
      .PPU_A10   (PPU_A10),
      .PPU_A11   (PPU_A11),
      .PPU_A12   (PPU_A12),
      .PRG_A14   (PRG_A14),
      .PRG_A15   (PRG_A15),
      .PRG_A16   (PRG_A16),
      .PRG_A17   (PRG_A17),
      .CHR_A12   (CHR_A12),
      .CHR_A13   (CHR_A13),
      .CHR_A14   (CHR_A14),
      .CHR_A15   (CHR_A15),
      .CHR_A16   (CHR_A16),
      .PRG_nCE   (PRG_nCE),
      .SRAM_CE   (SRAM_CE),
      .CIRAM_A10 (CIRAM_A10)
   );

   task automatic check(input string tag, input logic [4:0] observed, input logic [4:0] expected);
      n_assert++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, observed, expected);
      end
   endtask

   task automatic wr(input logic a14, input logic a13, input logic d0, input logic d7);
      @(negedge M2);
      CPU_A14 = a14; CPU_A13 = a13; CPU_D0 = d0; CPU_D7 = d7;
      nROMSEL = 1'b0; CPU_RnW = 1'b0;
      @(negedge M2);
      nROMSEL = 1'b1; CPU_RnW = 1'b1;
   endtask

   task automatic wr5(input logic a14, input logic a13, input logic [4:0] v);
      for (int i = 0; i < 5; i++) wr(a14, a13, v[i], 1'b0);
   endtask

   task automatic wr_double(input logic a14, input logic a13, input logic d0);
      @(negedge M2);
      CPU_A14 = a14; CPU_A13 = a13; CPU_D0 = d0; CPU_D7 = 1'b0;
      nROMSEL = 1'b0; CPU_RnW = 1'b0;
      @(negedge M2);
      @(negedge M2);
      nROMSEL = 1'b1; CPU_RnW = 1'b1;
   endtask

   task automatic bus_cycle(input logic nrom, input logic rnw, input logic d7);
      @(negedge M2);
      CPU_A14 = 1'b1; CPU_A13 = 1'b1; CPU_D0 = 1'b0; CPU_D7 = d7;
      nROMSEL = nrom; CPU_RnW = rnw;
      @(negedge M2);
      nROMSEL = 1'b1; CPU_RnW = 1'b1;
   endtask

   task automatic set_cpu(input logic nrom, input logic a14, input logic a13);
      nROMSEL = nrom; CPU_RnW = 1'b1; CPU_A14 = a14; CPU_A13 = a13;
      #1;
   endtask

   task automatic set_ppu(input logic a10, input logic a11, input logic a12);
      PPU_A10 = a10; PPU_A11 = a11; PPU_A12 = a12;
      #1;
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge M2);
      RST = 1'b0;
      set_cpu(1, 0, 0); check("rst_prg_lo", prg_a, 5'b00000);
      set_cpu(1, 1, 0); check("rst_prg_hi", prg_a, 5'b01111);
      set_ppu(1, 1, 1); check("rst_chr_hi", chr_a, 5'b00001);
      check("rst_ciram", {4'b0, CIRAM_A10}, 5'b00000);
      set_ppu(0, 0, 0); check("rst_chr_lo", chr_a, 5'b00000);
      set_cpu(1, 1, 1); check("rst_sram", {4'b0, SRAM_CE}, 5'b00001);
      check("rst_prg_nce", {4'b0, PRG_nCE}, 5'b00001);

      // PRG = 0x05, fixed-high mode
      wr5(1, 1, 5'h05);
      set_cpu(1, 0, 0); check("prg5_lo", prg_a, 5'b00101);
      set_cpu(1, 1, 0); check("prg5_hi", prg_a, 5'b01111);

      // Mirroring modes
      wr5(0, 0, 5'h02);
      set_ppu(1, 0, 0); check("mir_v_a10", {4'b0, CIRAM_A10}, 5'b00001);
      set_ppu(0, 1, 0); check("mir_v_a11", {4'b0, CIRAM_A10}, 5'b00000);
      wr5(0, 0, 5'h03);
      set_ppu(0, 1, 0); check("mir_h_a11", {4'b0, CIRAM_A10}, 5'b00001);
      set_ppu(1, 0, 0); check("mir_h_a10", {4'b0, CIRAM_A10}, 5'b00000);
      wr5(0, 0, 5'h01);
      set_ppu(0, 0, 0); check("mir_one_hi", {4'b0, CIRAM_A10}, 5'b00001);
      set_cpu(1, 0, 0); check("prg32_lo", prg_a, 5'b00100);
      set_cpu(1, 1, 0); check("prg32_hi", prg_a, 5'b00101);

      // 4 KB CHR banking
      wr5(0, 0, 5'h10);
      wr5(0, 1, 5'h03);
      wr5(1, 0, 5'h1A);
      set_ppu(0, 0, 0); check("chr4k_lo", chr_a, 5'b00011);
      set_ppu(0, 0, 1); check("chr4k_hi", chr_a, 5'b11010);

      // Partial load aborted by D7 write
      for (int i = 0; i < 3; i++) wr(0, 1, 1'b0, 1'b0);
      wr(0, 0, 1'b0, 1'b1);
      wr5(0, 1, 5'h1F);
      set_ppu(1, 1, 0); check("d7_chr0", chr_a, 5'b11111);
      check("d7_ciram_kept", {4'b0, CIRAM_A10}, 5'b00000);
      set_ppu(0, 0, 1); check("d7_ctrl4_kept", chr_a, 5'b11010);
      set_cpu(1, 1, 0); check("d7_prg_hi", prg_a, 5'b01111);
      set_cpu(1, 0, 0); check("d7_prg_lo", prg_a, 5'b00101);

      // Back-to-back writes count once
      wr_double(1, 0, 1'b1);
      for (int i = 0; i < 3; i++) wr(1, 0, 1'b0, 1'b0);
      set_ppu(0, 0, 1); check("dbl_not_loaded", chr_a, 5'b11010);
      wr(1, 0, 1'b0, 1'b0);
      set_ppu(0, 0, 1); check("dbl_loaded", chr_a, 5'b00001);

      // Reads and nROMSEL=1 writes leave the shifter alone
      wr(1, 1, 1'b1, 1'b0);
      bus_cycle(1'b0, 1'b1, 1'b1);
      wr(1, 1, 1'b1, 1'b0);
      bus_cycle(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) wr(1, 1, 1'b1, 1'b0);
      set_cpu(1, 1, 1); check("sram_off", {4'b0, SRAM_CE}, 5'b00000);
      set_cpu(1, 0, 0); check("prg1f_lo", prg_a, 5'b01111);
      wr5(1, 1, 5'h0E);
      set_cpu(1, 1, 1); check("sram_on", {4'b0, SRAM_CE}, 5'b00001);
      set_cpu(1, 0, 0); check("prg0e_lo", prg_a, 5'b01110);
      set_cpu(0, 0, 0); check("prg_nce_lo", {4'b0, PRG_nCE}, 5'b00000);
      set_cpu(1, 0, 0);

      // Asynchronous reset aborts a partial load
      for (int i = 0; i < 3; i++) wr(0, 0, 1'b1, 1'b0);
      @(negedge M2);
      #2 RST = 1'b1;
      set_cpu(1, 0, 0); check("arst_prg", prg_a, 5'b00000);
      set_ppu(0, 0, 0); check("arst_chr", chr_a, 5'b00000);
      @(negedge M2);
      RST = 1'b0;
      for (int i = 0; i < 2; i++) wr(0, 0, 1'b1, 1'b0);
      set_ppu(0, 1, 0); check("arst_no_load", {4'b0, CIRAM_A10}, 5'b00000);
      for (int i = 0; i < 3; i++) wr(0, 0, 1'b0, 1'b0);
      set_ppu(0, 1, 0); check("arst_reload", {4'b0, CIRAM_A10}, 5'b00001);
      set_cpu(1, 1, 0); check("arst_prg_mode", prg_a, 5'b00001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
